bitonic_unloader: RTL

BITONIC_UNLOADER -- requirements
Module: bitonic_unloader

---
 rtl/bitonic_unloader.sv | 106 ++++++++++
 1 files changed

// File: rtl/bitonic_unloader.sv
// Purpose: stream a sorted N-element vector out one element per beat, ascending index.
// Latency: first element valid 1 cycle after capture; back-to-back vectors with no bubble.
// Backpressure: out_ready low holds out_data/idx; in_ready only on the final accepted beat.
// Optional feature: define BITONIC_UNLOADER_LAST_EN to add the out_last port.
module bitonic_unloader #(
  parameter int DATA_WIDTH  = 8,
  parameter int BLOCK_DEPTH = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [(DATA_WIDTH<<BLOCK_DEPTH)-1:0]  data_in,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [DATA_WIDTH-1:0]                 out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
`ifdef BITONIC_UNLOADER_LAST_EN
  output logic                                  out_last,
`endif
  output logic                                  busy
);

  localparam int N  = 1 << BLOCK_DEPTH;
  localparam int IW = (BLOCK_DEPTH > 0) ? BLOCK_DEPTH : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [N*DATA_WIDTH-1:0]   vec_q;
  logic [IW-1:0]             idx;
  logic [DATA_WIDTH-1:0]     elem;
  logic                      at_last;
  logic                      capture;
  logic                      beat;

  assign at_last = (idx == LAST_IDX);

  // State register; reset discards any vector mid-stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake outputs and next state; a capture on the final beat keeps us in STREAM.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    capture   = 1'b0;
    beat      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
      end
      STREAM: begin
        out_valid = 1'b1;
        in_ready  = at_last && out_ready;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    capture = in_valid && in_ready;
    beat    = out_valid && out_ready;
    if (capture) begin
      state_nxt = STREAM;
    end else if (beat && at_last) begin
      state_nxt = IDLE;
    end
  end

  // Vector buffer and element index; idx only advances on non-final beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      vec_q <= '0;
      idx   <= '0;
    end else if (capture) begin
      vec_q <= data_in;
      idx   <= '0;
    end else if (beat && !at_last) begin
      idx   <= idx + IW'(1);
    end
  end

  // Select the element at idx from the held vector.
  always_comb begin
    elem = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IW'(i)) begin
        elem = vec_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign out_data = out_valid ? elem : '0;
  assign busy     = (state == STREAM);
`ifdef BITONIC_UNLOADER_LAST_EN
  assign out_last = out_valid && at_last;
`endif

endmodule
